prior_sel_seq_drain: RTL and testbench
======================================

# prior_sel_seq_drain

Sequential drain stage that sits directly downstream of the BCH decoder's flag-producing logic and wraps the priority-select path. It registers one vector of per-lane flags plus per-lane values. It then emits the flagged lanes one per handshake in priority order, clearing each lane after it is accepted. It turns the one-shot combinational priority pick into a valid/ready stream for the correction stage.

## Interface
- BIT_WIDTH, 2, width of each lane value.
- SEL_SIG_NUMS, 8, number of lanes/flags; must be ≥2.
- PRIORITY_DIRECTION, 1, ≥0 means the MSB lane (highest index) goes first; <0 means the LSB lane (index 0) goes first.
- IDX_WIDTH (localparam), ceil(log2(SEL_SIG_NUMS)), width of the lane index.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  load request.
- in_ready  out  1  block can accept a load.
- in_val  in  BIT_WIDTH*SEL_SIG_NUMS  lane values; lane i occupies bits [BIT_WIDTH*(i+1)-1 : BIT_WIDTH*i].
- in_flag  in  SEL_SIG_NUMS  lane i is to be emitted when in_flag[i]=1.
- out_valid  out  1  output beat present.
- out_ready  in  1  consumer accepts the beat.
- out_val  out  BIT_WIDTH  value of the selected lane; 0 on a none-beat.
- out_idx  out  IDX_WIDTH  index of the selected lane; 0 on a none-beat.
- out_last  out  1  this is the final beat of the current load.
- out_none  out  1  the load had no flags set; the beat carries no lane.
- out_cnt  out  IDX_WIDTH+1  popcount of in_flag captured at load; held until the next load.

## Operation
- There are two states: IDLE and DRAIN.
- IDLE:
  - in_ready=1 and out_valid=0.
  - On in_valid&&in_ready the block captures in_val into the value register, in_flag into the flag register, and popcount(in_flag) into out_cnt, then goes to DRAIN.
- DRAIN:
  - in_ready=0 and out_valid=1.
  - The selected lane is the highest-priority lane whose flag-register bit is set, per PRIORITY_DIRECTION.
  - out_val and out_idx are the selected lane's captured value and its index.
  - out_last=1 when exactly one flag bit remains.
- Handshake in DRAIN (out_valid&&out_ready):
  - The selected flag bit is cleared.
  - If out_last=1, the state returns to IDLE. Otherwise the block stays in DRAIN with the next lane selected.
- Zero-flag load:
  - The block still enters DRAIN and presents a single beat with out_none=1, out_last=1, out_val=0, out_idx=0.
  - On acceptance of that beat the block returns to IDLE.
- Lane values whose flag is 0 are never emitted; their contents do not matter.
- in_val and in_flag are ignored outside the load handshake. The captured values do not change during a drain.
- A load cannot overlap a drain. A load is accepted no earlier than the cycle after the last beat is accepted.
- While out_valid=1 and out_ready=0, out_val, out_idx, out_last and out_none hold stable.
- All output fields are derived only from registered state. There is no combinational path from in_* or out_ready to any out_* signal. in_ready depends on state only.

## Timing
- Reset (rst=1 at an edge) sets: state=IDLE, flag and value registers=0, out_cnt=0. Resulting outputs: in_ready=1, out_valid=0, out_val=0, out_idx=0, out_last=0, out_none=0.
- Reset has priority over every handshake in the same cycle.
- Reset mid-drain discards all remaining lanes. No beat is emitted after reset.
- Load latency: load handshake at edge N gives the first beat valid after edge N, i.e. in cycle N+1.
- Throughput: one beat per cycle while out_ready=1. A load with k flags set (k≥1) occupies DRAIN for exactly k cycles under continuous out_ready, then IDLE for at least 1 cycle.
- Zero-flag load: exactly 1 DRAIN cycle.
- out_cnt is valid from cycle N+1 and remains constant until the next load.

## Test plan
- Reset then idle (SEL_SIG_NUMS=8, BIT_WIDTH=2, PRIORITY_DIRECTION=1):
  - Stimulus: rst high for 2 cycles, then low.
  - Required: in_ready=1, out_valid=0, all out_* =0 from the first post-reset cycle.
- MSB priority:
  - Stimulus: load in_flag=8'b1010_0100 with lane i value = i mod 4; hold out_ready=1.
  - Required: beats with out_idx 7,5,2 and out_val 3,1,2 on consecutive cycles; out_last only on the third beat; out_cnt=3; in_ready=1 the cycle after the third beat.
- LSB priority:
  - Stimulus: same load with PRIORITY_DIRECTION=-1.
  - Required: out_idx order 2,5,7.
- Backpressure:
  - Stimulus: load in_flag=8'b0000_0011; drive out_ready=0 for 3 cycles, then 1.
  - Required: out_idx=1 and out_val held stable for all stalled cycles; then out_idx 1,0 are emitted with no lane lost or repeated.
- Zero flags:
  - Stimulus: load in_flag=0.
  - Required: exactly one beat with out_none=1, out_last=1, out_val=0, out_idx=0, out_cnt=0; IDLE after it is accepted.
- Reset mid-drain:
  - Stimulus: load in_flag=8'hFF; accept 2 beats; assert rst for 1 cycle.
  - Required: out_valid=0 and in_ready=1 after the reset edge; a fresh load of 8'h01 yields exactly one beat, out_idx=0.

Source files
------------

// File: rtl/prior_sel_seq_drain.sv
// Drain stage: captures one flag/value vector per load and emits the flagged
// lanes one per valid/ready handshake, highest priority first.
module prior_sel_seq_drain #(
  parameter int BIT_WIDTH          = 2,
  parameter int SEL_SIG_NUMS       = 8,
  parameter int PRIORITY_DIRECTION = 1,
  localparam int IDX_WIDTH         = $clog2(SEL_SIG_NUMS)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [BIT_WIDTH*SEL_SIG_NUMS-1:0] in_val,
  input  logic [SEL_SIG_NUMS-1:0]           in_flag,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [BIT_WIDTH-1:0]              out_val,
  output logic [IDX_WIDTH-1:0]              out_idx,
  output logic                              out_last,
  output logic                              out_none,
  output logic [IDX_WIDTH:0]                out_cnt,
  output logic [0:0]                        dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high; valid never waits on ready and payload holds while stalled.

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

  logic [0:0]                        state_q;
  logic [SEL_SIG_NUMS-1:0]           flag_q;
  logic [BIT_WIDTH*SEL_SIG_NUMS-1:0] val_q;
  logic [IDX_WIDTH:0]                cnt_q;

  logic [IDX_WIDTH-1:0]    sel_idx;
  logic [BIT_WIDTH-1:0]    sel_val;
  logic [SEL_SIG_NUMS-1:0] sel_onehot;
  logic                    sel_found;
  logic                    one_or_zero_left;
  logic [IDX_WIDTH:0]      load_cnt;

  // Later loop iterations overwrite earlier ones, so scan order sets priority.
  always_comb begin
    sel_idx    = '0;
    sel_val    = '0;
    sel_onehot = '0;
    sel_found  = 1'b0;
    if (PRIORITY_DIRECTION >= 0) begin
      for (int i = 0; i < SEL_SIG_NUMS; i++) begin
        if (flag_q[i]) begin
          sel_idx       = IDX_WIDTH'(i);
          sel_val       = val_q[i*BIT_WIDTH +: BIT_WIDTH];
          sel_onehot    = '0;
          sel_onehot[i] = 1'b1;
          sel_found     = 1'b1;
        end
      end
    end else begin
      for (int i = SEL_SIG_NUMS - 1; i >= 0; i--) begin
        if (flag_q[i]) begin
          sel_idx       = IDX_WIDTH'(i);
          sel_val       = val_q[i*BIT_WIDTH +: BIT_WIDTH];
          sel_onehot    = '0;
          sel_onehot[i] = 1'b1;
          sel_found     = 1'b1;
        end
      end
    end
  end

  always_comb begin
    load_cnt = '0;
    for (int i = 0; i < SEL_SIG_NUMS; i++) begin
      load_cnt = load_cnt + (IDX_WIDTH + 1)'(in_flag[i]);
    end
  end

  // True when at most one flag remains: covers the last lane and the none-beat.
  assign one_or_zero_left =
    ((flag_q & (flag_q - {{(SEL_SIG_NUMS-1){1'b0}}, 1'b1})) == '0);

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DRAIN);
  assign out_val   = out_valid ? sel_val : '0;
  assign out_idx   = out_valid ? sel_idx : '0;
  assign out_last  = out_valid && one_or_zero_left;
  assign out_none  = out_valid && !sel_found;
  assign out_cnt   = cnt_q;
  assign dbg_state = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      flag_q  <= '0;
      val_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            flag_q  <= in_flag;
            val_q   <= in_val;
            cnt_q   <= load_cnt;
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            flag_q <= flag_q & ~sel_onehot;
            if (out_last) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prior_sel_seq_drain.sv
// Directed bench for prior_sel_seq_drain: an MSB-first and an LSB-first
// instance share stimulus and are checked against hand-computed beat queues.
module tb_prior_sel_seq_drain;

  localparam int BW  = 2;
  localparam int N   = 8;
  localparam int IW  = 3;
  localparam int EW  = IW + BW;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [BW*N-1:0] in_val;
  logic [N-1:0]  in_flag;
  logic          out_ready;

  logic          in_ready_m, out_valid_m, out_last_m, out_none_m;
  logic [BW-1:0] out_val_m;
  logic [IW-1:0] out_idx_m;
  logic [IW:0]   out_cnt_m;
  logic [0:0]    dbg_state_m;

  logic          in_ready_l, out_valid_l, out_last_l, out_none_l;
  logic [BW-1:0] out_val_l;
  logic [IW-1:0] out_idx_l;
  logic [IW:0]   out_cnt_l;
  logic [0:0]    dbg_state_l;

  logic [EW-1:0] exp_m_q[$];
  logic [EW-1:0] exp_l_q[$];

  int n_checks = 0;
  int n_errors = 0;

  prior_sel_seq_drain #(.BIT_WIDTH(BW), .SEL_SIG_NUMS(N), .PRIORITY_DIRECTION(1)) dut_m (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_m),
    .in_val(in_val), .in_flag(in_flag), .out_valid(out_valid_m),
    .out_ready(out_ready), .out_val(out_val_m), .out_idx(out_idx_m),
    .out_last(out_last_m), .out_none(out_none_m), .out_cnt(out_cnt_m),
    .dbg_state(dbg_state_m)
  );

  prior_sel_seq_drain #(.BIT_WIDTH(BW), .SEL_SIG_NUMS(N), .PRIORITY_DIRECTION(-1)) dut_l (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_l),
    .in_val(in_val), .in_flag(in_flag), .out_valid(out_valid_l),
    .out_ready(out_ready), .out_val(out_val_l), .out_idx(out_idx_l),
    .out_last(out_last_l), .out_none(out_none_l), .out_cnt(out_cnt_l),
    .dbg_state(dbg_state_l)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Driver tasks
  task automatic load(input logic [N-1:0] flag, input logic [BW*N-1:0] val);
    in_valid = 1'b1;
    in_flag  = flag;
    in_val   = val;
    tick();
    in_valid = 1'b0;
    in_flag  = '0;
    in_val   = '0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " m in_ready"}, in_ready_m, 1);
    check({tag, " m out_valid"}, out_valid_m, 0);
    check({tag, " l in_ready"}, in_ready_l, 1);
    check({tag, " l out_valid"}, out_valid_l, 0);
  endtask

  // Scoreboard: one beat per cycle under continuous out_ready.
  task automatic drain_check(input string tag, input int n, input int cnt);
    logic [EW-1:0] em, el;
    out_ready = 1'b1;
    for (int b = 0; b < n; b++) begin
      em = (exp_m_q.size() > 0) ? exp_m_q.pop_front() : '1;
      el = (exp_l_q.size() > 0) ? exp_l_q.pop_front() : '1;
      check({tag, " m valid"}, out_valid_m, 1);
      check({tag, " m idx/val"}, {out_idx_m, out_val_m}, em);
      check({tag, " m last"}, out_last_m, (b == n - 1) ? 1 : 0);
      check({tag, " m none"}, out_none_m, 0);
      check({tag, " m cnt"}, out_cnt_m, cnt);
      check({tag, " l valid"}, out_valid_l, 1);
      check({tag, " l idx/val"}, {out_idx_l, out_val_l}, el);
      check({tag, " l last"}, out_last_l, (b == n - 1) ? 1 : 0);
      tick();
    end
    check({tag, " queues empty"}, exp_m_q.size() + exp_l_q.size(), 0);
    check_idle({tag, " after"});
    check({tag, " m cnt held"}, out_cnt_m, cnt);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_val = '0; in_flag = '0; out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset then idle
    check_idle("reset");
    check("reset m val", out_val_m, 0);
    check("reset m idx", out_idx_m, 0);
    check("reset m last", out_last_m, 0);
    check("reset m none", out_none_m, 0);
    check("reset m cnt", out_cnt_m, 0);
    check("reset l cnt", out_cnt_l, 0);
    tick();
    check_idle("reset+1");

    // Priority order, lane i value = i mod 4
    exp_m_q.push_back({3'd7, 2'd3}); exp_m_q.push_back({3'd5, 2'd1}); exp_m_q.push_back({3'd2, 2'd2});
    exp_l_q.push_back({3'd2, 2'd2}); exp_l_q.push_back({3'd5, 2'd1}); exp_l_q.push_back({3'd7, 2'd3});
    out_ready = 1'b1;
    load(8'b1010_0100, 16'hE4E4);
    check("prio m in_ready busy", in_ready_m, 0);
    drain_check("prio", 3, 3);

    // Backpressure: lane0=2, lane1=3; a load attempt while stalled is ignored
    out_ready = 1'b0;
    load(8'b0000_0011, 16'h000E);
    in_valid = 1'b1; in_flag = 8'hFF; in_val = 16'hFFFF;
    for (int c = 0; c < 3; c++) begin
      check("stall m idx", out_idx_m, 1);
      check("stall m val", out_val_m, 3);
      check("stall m last", out_last_m, 0);
      check("stall l idx", out_idx_l, 0);
      check("stall l val", out_val_l, 2);
      check("stall m in_ready", in_ready_m, 0);
      tick();
    end
    in_valid = 1'b0; in_flag = '0; in_val = '0;
    exp_m_q.push_back({3'd1, 2'd3}); exp_m_q.push_back({3'd0, 2'd2});
    exp_l_q.push_back({3'd0, 2'd2}); exp_l_q.push_back({3'd1, 2'd3});
    drain_check("bp", 2, 2);

    // Zero flags: values must not leak onto the none-beat
    out_ready = 1'b0;
    load(8'h00, 16'hFFFF);
    check("zero m valid", out_valid_m, 1);
    check("zero m none", out_none_m, 1);
    check("zero m last", out_last_m, 1);
    check("zero m val", out_val_m, 0);
    check("zero m idx", out_idx_m, 0);
    check("zero m cnt", out_cnt_m, 0);
    check("zero l none", out_none_l, 1);
    out_ready = 1'b1;
    tick();
    check_idle("zero after");
    check("zero m none after", out_none_m, 0);

    // Reset mid-drain
    out_ready = 1'b1;
    load(8'hFF, 16'hE4E4);
    check("rst m cnt", out_cnt_m, 8);
    check("rst m beat0", {out_idx_m, out_val_m}, {3'd7, 2'd3});
    tick();
    check("rst m beat1", {out_idx_m, out_val_m}, {3'd6, 2'd2});
    check("rst l beat1", {out_idx_l, out_val_l}, {3'd1, 2'd1});
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("rst after");
    check("rst m cnt cleared", out_cnt_m, 0);
    tick();
    check_idle("rst after+1");
    exp_m_q.push_back({3'd0, 2'd1});
    exp_l_q.push_back({3'd0, 2'd1});
    load(8'h01, 16'h0001);
    drain_check("reload", 1, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
